// File: rtl/fetch_align_queue.sv
// fetch_align_queue: instruction fetch unit with a parcel-aligned queue.
//
// Fetches 32-bit words from instruction memory (one outstanding request),
// splits them into 16-bit parcels held in a circular queue, and presents
// complete instructions (16- or 32-bit) at the queue head.
//
// Optional feature macro: COMPRESS_EN
//   defined   : mixed 16/32-bit instructions; a head parcel with [1:0]=2'b11
//               is the low half of a 32-bit instruction, anything else is a
//               16-bit instruction. Fetch from an odd-halfword PC enqueues
//               only rdata[31:16].
//   undefined : every instruction is 32 bits (two parcels), redirect_pc[1:0]
//               is forced to 0 and both halfwords are always enqueued.
//
// Parameters:
//   DEPTH    queue capacity in 16-bit parcels (power of 2, >= 4)
//   RESET_PC first fetch address after reset
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   redirect_valid/redirect_pc flush queue and restart fetch at redirect_pc
//   imem_valid/imem_addr       fetch request (held until imem_ready)
//   imem_ready/imem_rdata      fetch response strobe and data
//   instr_valid/instr/instr_pc instruction at queue head and its address
//   instr_ready                consumer accepts instr
//   fill                       parcels currently queued
module fetch_align_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_valid,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ready,
  input  logic [31:0]              imem_rdata,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned FW = PW + 1;

`ifdef COMPRESS_EN
  localparam logic [31:0] PC_MASK = 32'hffff_fffe;
`else
  localparam logic [31:0] PC_MASK = 32'hffff_fffc;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t          state;
  logic [15:0]     q [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [FW-1:0]   fill_q;
  logic [31:0]     fetch_pc;
  logic [31:0]     req_addr;
  logic [31:0]     pc_q;

  logic [FW-1:0]   free;
  logic            issue;
  logic [15:0]     p0;
  logic [15:0]     p1;
  logic            head_is32;
  logic [FW-1:0]   need;
  logic            head_ok;
  logic            resp;
  logic            enq_two;
  logic [FW-1:0]   enq_n;
  logic [FW-1:0]   deq_n;
  logic [31:0]     redir_tgt;
  logic            unused_bits;

  assign redir_tgt   = redirect_pc & PC_MASK;
  assign unused_bits = ^{fetch_pc[1:0]};

  always_comb begin
    free  = FW'(DEPTH) - fill_q;
    issue = (state == IDLE) && !redirect_valid && (free >= FW'(2));
    p0    = q[rd_ptr];
    p1    = q[rd_ptr + PW'(1)];
`ifdef COMPRESS_EN
    head_is32 = (p0[1:0] == 2'b11);
    enq_two   = !fetch_pc[1];
`else
    head_is32 = 1'b1;
    enq_two   = 1'b1;
`endif
    need    = head_is32 ? FW'(2) : FW'(1);
    head_ok = (fill_q >= need);
    // Redirect masks the head so no handshake can complete in a flush cycle.
    instr_valid = !rst && !redirect_valid && head_ok;
    instr       = '0;
    if (instr_valid) begin
      instr = head_is32 ? {p1, p0} : {16'h0000, p0};
    end
    instr_pc = pc_q;
    fill     = fill_q;
    deq_n    = (instr_valid && instr_ready) ? need : '0;
    resp     = (state == WAIT) && imem_ready && !redirect_valid;
    enq_n    = '0;
    if (resp) begin
      enq_n = enq_two ? FW'(2) : FW'(1);
    end
    imem_valid = !rst && (issue || (state == WAIT) || (state == DROP));
    imem_addr  = (state == IDLE) ? (fetch_pc & 32'hffff_fffc) : req_addr;
  end

  // Parcel storage; contents need no reset since fill gates visibility.
  always_ff @(posedge clk) begin
    if (resp) begin
      if (enq_two) begin
        q[wr_ptr]            <= imem_rdata[15:0];
        q[wr_ptr + PW'(1)]   <= imem_rdata[31:16];
      end else begin
        q[wr_ptr]            <= imem_rdata[31:16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fill_q   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= RESET_PC & PC_MASK;
      pc_q     <= RESET_PC & PC_MASK;
      req_addr <= RESET_PC & 32'hffff_fffc;
    end else if (redirect_valid) begin
      fill_q   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= redir_tgt;
      pc_q     <= redir_tgt;
      // A response arriving together with the redirect still retires the
      // outstanding request (its data is discarded), so there is nothing
      // left to drop in that case.
      case (state)
        IDLE:    state <= issue ? DROP : IDLE;
        WAIT:    state <= imem_ready ? IDLE : DROP;
        DROP:    state <= imem_ready ? IDLE : DROP;
        default: state <= IDLE;
      endcase
    end else begin
      fill_q <= fill_q + enq_n - deq_n;
      wr_ptr <= wr_ptr + PW'(enq_n);
      rd_ptr <= rd_ptr + PW'(deq_n);
      pc_q   <= pc_q + (32'(deq_n) << 1);
      case (state)
        IDLE: begin
          if (issue) begin
            req_addr <= fetch_pc & 32'hffff_fffc;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ready) begin
            fetch_pc <= (fetch_pc & 32'hffff_fffc) + 32'd4;
            state    <= IDLE;
          end
        end
        DROP: begin
          if (imem_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_align_queue.sv
// tb_fetch_align_queue: directed self-checking bench for fetch_align_queue.
// A small memory responder answers fetches after a programmable latency;
// expected instructions are derived from the bench's own memory image.
module tb_fetch_align_queue;

  localparam int DEPTH = 8;
`ifdef COMPRESS_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  logic                   clk;
  logic                   rst;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
  logic                   imem_valid;
  logic [31:0]            imem_addr;
  logic                   imem_ready;
  logic [31:0]            imem_rdata;
  logic                   instr_valid;
  logic [31:0]            instr;
  logic [31:0]            instr_pc;
  logic                   instr_ready;
  logic [$clog2(DEPTH):0] fill;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] memarr [256];
  int mem_lat     = 1;
  bit force_ready = 1'b0;
  int wait_cnt    = 0;

  fetch_align_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_valid(imem_valid), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .fill(fill)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: answers mem_lat cycles after a request first appears.
  initial begin
    imem_ready = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (imem_valid && !imem_ready) wait_cnt++;
      else wait_cnt = 0;
      @(posedge clk);
      #1;
      if (force_ready) begin
        imem_ready = 1'b1;
        imem_rdata = 32'hdead_beef;
      end else if (wait_cnt > 0 && wait_cnt >= mem_lat) begin
        imem_ready = 1'b1;
        imem_rdata = memarr[imem_addr[9:2]];
      end else begin
        imem_ready = 1'b0;
        imem_rdata = '0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] parcel(input logic [31:0] a);
    logic [31:0] w;
    w = memarr[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic int need(input logic [31:0] pc);
    logic [15:0] p;
    p = parcel(pc);
    if (CMP && p[1:0] != 2'b11) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    if (need(pc) == 2) return {parcel(pc + 32'd2), parcel(pc)};
    return {16'h0000, parcel(pc)};
  endfunction

  // Streams from 'start' for 'cycles' cycles with instr_ready low for the
  // first 'hold' cycles, tracking fill and the instruction sequence.
  task automatic stream(input logic [31:0] start, input bit do_redir,
                        input int hold, input int cycles, input string tag);
    logic [31:0] epc;
    logic [31:0] efetch;
    int efill;
    int nd;
    int ne;
    int ninstr;
    bit ev;
    epc    = CMP ? {start[31:1], 1'b0} : {start[31:2], 2'b00};
    efetch = epc;
    if (do_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = start;
      #1;
      check({tag, "_redir_iv"}, 32'(instr_valid), 32'd0);
      tick();
      redirect_valid = 1'b0;
    end
    efill  = 0;
    ninstr = 0;
    for (int k = 0; k < cycles; k++) begin
      instr_ready = (k >= hold);
      #1;
      check({tag, "_fill"}, 32'(fill), 32'(efill));
      ev = (efill >= need(epc));
      check({tag, "_iv"}, 32'(instr_valid), 32'(ev));
      nd = 0;
      if (ev && instr_ready) begin
        check({tag, "_instr"}, instr, exp_instr(epc));
        check({tag, "_pc"}, instr_pc, epc);
        nd = need(epc);
        epc = epc + 32'(2 * nd);
        ninstr++;
      end
      ne = 0;
      if (imem_ready && imem_addr == {efetch[31:2], 2'b00}) begin
        ne = (CMP && efetch[1]) ? 1 : 2;
        efetch = {efetch[31:2] + 30'd1, 2'b00};
      end
      if (hold >= 20 && k == hold - 1) begin
        check({tag, "_sat_fill"}, 32'(fill), 32'(DEPTH));
        check({tag, "_sat_noreq"}, 32'(imem_valid), 32'd0);
      end
      efill = efill + ne - nd;
      tick();
    end
    check({tag, "_progress"}, 32'(ninstr > 0), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      memarr[i] = {16'h1000 + 16'(i), 16'h0013 + 16'(i * 256)};
    end
    memarr[0] = 32'h00a00093;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    #1;
    check("rst_imem_valid", 32'(imem_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", instr_pc, 32'd0);

    // First fetch at RESET_PC, 1-cycle memory latency
    rst = 1'b0;
    #1;
    check("first_req_valid", 32'(imem_valid), 32'd1);
    check("first_req_addr", imem_addr, 32'h0);
    tick();
    #1;
    check("resp_cycle_ready", 32'(imem_ready), 32'd1);
    check("resp_cycle_iv", 32'(instr_valid), 32'd0);
    tick();
    #1;
    check("first_iv", 32'(instr_valid), 32'd1);
    check("first_instr", instr, 32'h00a00093);
    check("first_pc", instr_pc, 32'h0);
    check("next_req_valid", 32'(imem_valid), 32'd1);
    check("next_req_addr", imem_addr, 32'h4);
    instr_ready = 1'b1;

    // Redirect to 0x102 while a request is outstanding
    mem_lat = 3;
    tick();
    for (int i = 0; i < 20 && !imem_ready; i++) tick();
    check("redir_wait_resp", 32'(imem_ready), 32'd1);
    tick();
    tick();
    begin
      logic [31:0] old_addr;
      old_addr = imem_addr;
      redirect_valid = 1'b1;
      redirect_pc = 32'h102;
      #1;
      check("redir_iv_forced", 32'(instr_valid), 32'd0);
      check("redir_wait_valid", 32'(imem_valid), 32'd1);
      tick();
      redirect_valid = 1'b0;
      mem_lat = 1;
      #1;
      check("redir_fill", 32'(fill), 32'd0);
      check("redir_pc", instr_pc, CMP ? 32'h102 : 32'h100);
      check("drop_valid", 32'(imem_valid), 32'd1);
      check("drop_addr", imem_addr, old_addr);
    end
    stream(32'h102, 1'b0, 0, 20, "redir");

`ifdef COMPRESS_EN
    // Two 16-bit instructions in one word
    memarr[0] = 32'h4501_4505;
    stream(32'h0, 1'b1, 0, 12, "rvc");
    memarr[0] = 32'h00a00093;
`endif

    // Backpressure: queue fills to DEPTH, then drains in order
    stream(32'h200, 1'b1, 20, 40, "sat");

    // Streaming across the pointer wrap with overlapping enq/deq
    stream(32'h302, 1'b1, 6, 40, "wrap");

    // Reset while a request is outstanding
    mem_lat = 3;
    instr_ready = 1'b1;
    tick();
    for (int i = 0; i < 20 && !imem_ready; i++) tick();
    check("rstw_wait_resp", 32'(imem_ready), 32'd1);
    tick();
    tick();
    rst = 1'b1;
    force_ready = 1'b1;
    tick();
    #1;
    check("rstw_imem_valid", 32'(imem_valid), 32'd0);
    check("rstw_instr_valid", 32'(instr_valid), 32'd0);
    check("rstw_fill", 32'(fill), 32'd0);
    check("rstw_instr", instr, 32'd0);
    check("rstw_pc", instr_pc, 32'd0);
    tick();
    rst = 1'b0;
    mem_lat = 1;
    #1;
    check("rstw_req_valid", 32'(imem_valid), 32'd1);
    check("rstw_req_addr", imem_addr, 32'h0);
    force_ready = 1'b0;
    tick();
    for (int i = 0; i < 10 && !instr_valid; i++) tick();
    #1;
    check("rstw_iv", 32'(instr_valid), 32'd1);
    check("rstw_instr_after", instr, 32'h00a00093);
    check("rstw_pc_after", instr_pc, 32'h0);
    check("rstw_fill_after", 32'(fill), 32'd2);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_align_queue.md
FETCH_ALIGN_QUEUE -- requirements
Module: fetch_align_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8: queue capacity in 16-bit parcels; power of 2, minimum 4.
REQ-002 SHALL have parameter RESET_PC, default 32'h0: first fetch address after reset.
REQ-003 SHALL have port clk  in  1  clock; single clock domain, all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port redirect_valid  in  1  flush queue and restart fetch (trap, mret, jump).
REQ-006 SHALL have port redirect_pc  in  32  new fetch PC; bit 0 ignored.
REQ-007 SHALL have port imem_valid  out  1  fetch request, held until imem_ready.
REQ-008 SHALL have port imem_addr  out  32  word-aligned fetch address, stable while imem_valid.
REQ-009 SHALL have port imem_ready  in  1  response strobe; imem_rdata valid in the same cycle.
REQ-010 SHALL have port imem_rdata  in  32  fetched word.
REQ-011 SHALL have port instr_valid  out  1  complete instruction at queue head.
REQ-012 SHALL have port instr  out  32  instruction; 16-bit parcels zero-extended.
REQ-013 SHALL have port instr_pc  out  32  address of instr.
REQ-014 SHALL have port instr_ready  in  1  consumer accepts instr.
REQ-015 SHALL have port fill  out  $clog2(DEPTH)+1  parcels currently queued.

Function
REQ-016 SHALL implement FSM {IDLE, WAIT, DROP}: IDLE issues a request; WAIT awaits imem_ready; DROP awaits imem_ready and discards its data.
REQ-017 SHALL allow at most one outstanding request; in IDLE, assert imem_valid only when free parcels >= 2 and redirect_valid=0, then enter WAIT.
REQ-018 SHALL, in WAIT on imem_ready, enqueue parcels, advance fetch PC to next word boundary, return to IDLE.
REQ-019 SHALL enqueue both halfwords (low first) for an aligned fetch PC; only rdata[31:16] when fetch PC bit 1 = 1.
REQ-020 SHALL treat a head parcel with bits [1:0]=2'b11 as 32-bit: instr_valid needs fill >= 2, instr = {parcel1,parcel0}; otherwise 16-bit, needs fill >= 1.
REQ-021 SHALL dequeue 1 or 2 parcels on instr_valid & instr_ready, advancing instr_pc by 2 or 4.
REQ-022 SHALL apply enqueue and dequeue in the same cycle; fill = fill + enq - deq; never overflow or underflow.
REQ-023 SHALL wrap read/write pointers modulo DEPTH; an instruction straddling the wrap point is reassembled correctly.
REQ-024 SHALL, on redirect_valid, flush the queue (fill=0), force instr_valid=0 in that cycle, load fetch PC and instr_pc from redirect_pc; from WAIT, or from IDLE with a request issuing in that cycle, enter DROP, else IDLE.
REQ-025 SHALL, in DROP on imem_ready, discard data and go to IDLE; a further redirect in DROP only updates fetch PC.
REQ-026 SHALL give redirect priority over a simultaneous response and handshake; neither takes effect that cycle.
REQ-027 SHALL produce the first instruction no earlier than one cycle after its imem_ready (registered queue output).

Reset
REQ-028 SHALL, while rst=1, hold: FSM IDLE, fill 0, pointers 0, fetch PC and instr_pc = RESET_PC, imem_valid 0, instr_valid 0, instr 0.
REQ-029 SHALL abandon any outstanding request at reset and issue the first request at RESET_PC in the first cycle after rst falls.

Configuration
REQ-030 SHALL, with COMPRESS_EN defined, implement mixed 16/32-bit handling per REQ-019..021.
REQ-031 SHALL, without COMPRESS_EN, treat every instruction as 32-bit (two parcels regardless of [1:0]), force redirect_pc[1:0] to 0, and always enqueue both halfwords.

Verification
REQ-032 SHALL cover: reset, memory returns 32'h00a00093 at 0 with 1-cycle latency -> instr=32'h00a00093, instr_pc=0, then request at 4.
REQ-033 SHALL cover (COMPRESS_EN): word at 0 = 32'h4501_4505 -> instr 32'h4505 pc 0, then 32'h4501 pc 2.
REQ-034 SHALL cover: redirect to 32'h102 during WAIT -> data for old address dropped, next request addr 32'h100, first instr from rdata[31:16], pc 32'h102.
REQ-035 SHALL cover: instr_ready=0 for 20 cycles -> fill saturates at DEPTH (or DEPTH-1), no request while free < 2, no parcel lost.
REQ-036 SHALL cover: 32-bit instruction spanning pointer wrap with simultaneous enq/deq -> correct instr, fill consistent.
REQ-037 SHALL cover: rst asserted during WAIT -> all outputs at reset values next cycle, late imem_ready ignored.
